alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-precision sequencer for the shared `ALU` datapath. It accepts one WORDS×N-bit operation per request and runs it through the N-bit ALU one word at a time, least-significant word first. Carry is chained between words, and the per-word flags are combined into a single flag set. It sits between the control unit and the `ALU` instance, owning the ALU's A, B, FuncOp, IFlags and OE inputs while busy.

## Interface
- `N`, 8, ALU word width
- `WORDS`, 4, words per operand (≥2)
- `FlagBits`, 4, flag width {V,N,C,Z}
- Clock is `Clk` and reset is `Reset` (already decided): one clock; reset is asynchronous and active-high.
- `Clk`  in  1  clock, rising edge
- `Reset`  in  1  async active-high reset
- `Start`  in  1  request strobe, sampled only in IDLE
- `OpSel`  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR
- `CarryIn`  in  1  carry into word 0 (ADD only)
- `Abort`  in  1  cancel current operation (see Configuration)
- `OpA`, `OpB`  in  N*WORDS  operands, latched at Start
- `Busy`  out  1  operation in progress
- `Done`  out  1  one-cycle completion pulse
- `Result`  out  N*WORDS  last completed result
- `Flags`  out  FlagBits  last completed flags {V,N,C,Z}
- `AluA`, `AluB`  out  N  registered ALU operands
- `AluFuncOp`  out  4  registered ALU op code
- `AluIFlags`  out  FlagBits  registered; only bit 1 (C) used, others 0
- `AluOE`  out  1  active-low ALU output enable
- `AluY`  in  N  ALU result
- `AluOFlags`  in  FlagBits  ALU flags

## Operation
- States: IDLE, ISSUE, DONE.
- Reset values:
  - state IDLE
  - Busy=0, Done=0
  - Result=0, Flags=0
  - AluA=0, AluB=0, AluFuncOp=0000, AluIFlags=0
  - AluOE=1
  - word index i=0
- IDLE, Start=1:
  - latch OpA, OpB and OpSel
  - register word 0 onto AluA/AluB
  - go to ISSUE with i=0, Busy=1, AluOE=0
- Op code per word:
  - ADD: Add_OP (0000) on every word
  - SUB: Sub_OP (0001) on word 0; Subc_OP (0010) on words 1..WORDS-1
  - AND: And_OP (0011)
  - XOR: Xor_OP (0110)
- Carry into the ALU (AluIFlags[1]):
  - word 0: CarryIn for ADD, 0 for all other ops
  - word i>0: AluOFlags[1] captured from word i-1, forwarded unmodified for ADD and SUB; 0 for AND/XOR
- ISSUE, each edge:
  - capture AluY into working word i
  - AND AluOFlags[0] into a running zero accumulator
  - keep AluOFlags[1] as the chained carry
  - if i<WORDS-1: i+1, register the next word's ALU inputs, stay in ISSUE
  - else: go to DONE
- DONE:
  - copy the working register into Result
  - Flags = {last V, last N, last C, accumulated Z}
  - Done=1, Busy=0, AluOE=1
  - next edge: IDLE
- Result and Flags change only on DONE; they hold between operations.
- Start in ISSUE or DONE is ignored, not queued.
- Reset mid-operation: everything returns to reset values at once; no Done is generated.

## Timing
- Start sampled at edge 0; word k is captured at edge k+1.
- Done is high for the cycle after edge WORDS; throughput is one op per WORDS+2 cycles.
- ALU inputs are registered and stable for a full cycle before capture; the ALU's internal delays must settle within one Clk period.
- AluOE is low only in ISSUE; AluY is sampled only while AluOE=0.
- Next Start is accepted the cycle after Done (IDLE).

## Configuration
- `ALU_SEQ_ABORT_EN` defined:
  - Abort=1 in ISSUE forces IDLE on the next edge
  - Busy=0 and AluOE=1 from then on
  - no Done; Result and Flags keep their previous values
- Not defined: the Abort port exists but is ignored, and every accepted operation runs to Done.

## Test plan
- ADD 0x00FFFFFF+0x00000001, CarryIn=0 -> Result 0x01000000, Flags V0 N0 C0 Z0, Done exactly at cycle after edge 4.
- ADD 0xFFFFFFFF+0x00000001 -> Result 0x00000000, C=1, Z=1, N=0, V=0.
- SUB 0x00000005−0x00000003 -> Result 0x00000002, C=0, Z=0; AluFuncOp sequence 0001,0010,0010,0010.
- XOR 0xA5A5A5A5^0xFFFF0000 -> Result 0x5A5AA5A5, C=0, N=0, Z=0; Start pulsed during ISSUE ignored, one Done only.
- With `ALU_SEQ_ABORT_EN`: Abort at word 2 -> no Done, Result/Flags unchanged, Busy=0 next cycle. Without it: same stimulus completes normally.
- Reset asserted mid-ISSUE -> Busy, Done, Result and Flags all 0 and AluOE=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-precision sequencer: runs one WORDS*N-bit operation through an N-bit ALU,
// least-significant word first. Optional macro ALU_SEQ_ABORT_EN enables Abort.
module alu_sequencer #(
    parameter int N        = 8,
    parameter int WORDS    = 4,
    parameter int FlagBits = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            OpSel,
    input  logic                  CarryIn,
    input  logic                  Abort,
    input  logic [N*WORDS-1:0]    OpA,
    input  logic [N*WORDS-1:0]    OpB,
    output logic                  Busy,
    output logic                  Done,
    output logic [N*WORDS-1:0]    Result,
    output logic [FlagBits-1:0]   Flags,
    output logic [N-1:0]          AluA,
    output logic [N-1:0]          AluB,
    output logic [3:0]            AluFuncOp,
    output logic [FlagBits-1:0]   AluIFlags,
    output logic                  AluOE,
    input  logic [N-1:0]          AluY,
    input  logic [FlagBits-1:0]   AluOFlags
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;
    logic [W-1:0]    work_r;
    logic [1:0]      opsel_r;
    logic [IW-1:0]   idx_r;
    logic            zacc_r;
    logic            abort_s;

    // ALU op code for a word; subtraction borrows through Subc on upper words
    function automatic logic [3:0] op_code(input logic [1:0] sel, input logic first);
        logic [3:0] code;
        case (sel)
            2'b00:   code = 4'b0000;
            2'b01:   code = first ? 4'b0001 : 4'b0010;
            2'b10:   code = 4'b0011;
            2'b11:   code = 4'b0110;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Incoming flag vector; only the carry position is ever non-zero
    function automatic logic [FlagBits-1:0] in_flags(input logic [1:0] sel, input logic first,
                                                     input logic cin, input logic chain);
        logic c;
        case (sel)
            2'b00:   c = first ? cin : chain;
            2'b01:   c = first ? 1'b0 : chain;
            default: c = 1'b0;
        endcase
        return {{(FlagBits-2){1'b0}}, c, 1'b0};
    endfunction

`ifdef ALU_SEQ_ABORT_EN
    assign abort_s = Abort;
`else
    // Port stays on the interface but has no effect in this build
    assign abort_s = Abort & 1'b0;
`endif

    // Sequencer state, operand shifters, result assembly and registered ALU drive
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            opa_r     <= '0;
            opb_r     <= '0;
            work_r    <= '0;
            opsel_r   <= 2'b00;
            idx_r     <= '0;
            zacc_r    <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Result    <= '0;
            Flags     <= '0;
            AluA      <= '0;
            AluB      <= '0;
            AluFuncOp <= 4'b0000;
            AluIFlags <= '0;
            AluOE     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        opa_r     <= OpA >> N;
                        opb_r     <= OpB >> N;
                        opsel_r   <= OpSel;
                        AluA      <= OpA[N-1:0];
                        AluB      <= OpB[N-1:0];
                        AluFuncOp <= op_code(OpSel, 1'b1);
                        AluIFlags <= in_flags(OpSel, 1'b1, CarryIn, 1'b0);
                        idx_r     <= '0;
                        zacc_r    <= 1'b1;
                        Busy      <= 1'b1;
                        AluOE     <= 1'b0;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort_s) begin
                        idx_r   <= '0;
                        Busy    <= 1'b0;
                        AluOE   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        work_r <= {AluY, work_r[W-1:N]};
                        zacc_r <= zacc_r & AluOFlags[0];
                        if (idx_r != IW'(WORDS - 1)) begin
                            idx_r     <= idx_r + IW'(1);
                            AluA      <= opa_r[N-1:0];
                            AluB      <= opb_r[N-1:0];
                            opa_r     <= opa_r >> N;
                            opb_r     <= opb_r >> N;
                            AluFuncOp <= op_code(opsel_r, 1'b0);
                            AluIFlags <= in_flags(opsel_r, 1'b0, 1'b0, AluOFlags[1]);
                        end else begin
                            // Last word goes straight into Result so Done coincides with it
                            Result  <= {AluY, work_r[W-1:N]};
                            Flags   <= {AluOFlags[FlagBits-1:1], zacc_r & AluOFlags[0]};
                            idx_r   <= '0;
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            AluOE   <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    Done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    AluOE   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU model.
module tb_alu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  OpSel = 2'b00;
    logic        CarryIn = 1'b0;
    logic        Abort = 1'b0;
    logic [31:0] OpA = 32'd0;
    logic [31:0] OpB = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic [7:0]  AluA;
    logic [7:0]  AluB;
    logic [3:0]  AluFuncOp;
    logic [3:0]  AluIFlags;
    logic        AluOE;
    logic [7:0]  AluY;
    logic [3:0]  AluOFlags;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.N(8), .WORDS(4), .FlagBits(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OpSel(OpSel), .CarryIn(CarryIn),
        .Abort(Abort), .OpA(OpA), .OpB(OpB), .Busy(Busy), .Done(Done),
        .Result(Result), .Flags(Flags), .AluA(AluA), .AluB(AluB),
        .AluFuncOp(AluFuncOp), .AluIFlags(AluIFlags), .AluOE(AluOE),
        .AluY(AluY), .AluOFlags(AluOFlags)
    );

    always #5 Clk = ~Clk;

    // Behavioural ALU: returns {V,N,C,Z,Y}; C is carry for add, borrow for subtract
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f, input logic cin);
        logic [8:0] t;
        logic       v;
        t = 9'd0;
        v = 1'b0;
        case (f)
            4'b0000: begin
                t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                v = (a[7] == b[7]) && (t[7] != a[7]);
            end
            4'b0001: begin
                t = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (t[7] != a[7]);
            end
            4'b0010: begin
                t = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                v = (a[7] != b[7]) && (t[7] != a[7]);
            end
            4'b0011: t = {1'b0, a & b};
            4'b0110: t = {1'b0, a ^ b};
            default: t = 9'd0;
        endcase
        return {v, t[7], t[8], (t[7:0] == 8'd0), t[7:0]};
    endfunction

    always_comb begin
        {AluOFlags, AluY} = alu_model(AluA, AluB, AluFuncOp, AluIFlags[1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation; observes 12 cycles after Start so any extra Done would be counted
    task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic glitch, input logic abrt,
                          output int done_at, output int dones, output logic [15:0] seq,
                          output logic busy0, output logic oe0, output logic busy_ab);
        @(negedge Clk);
        OpSel = sel; OpA = a; OpB = b; CarryIn = cin; Start = 1'b1;
        @(posedge Clk); #1;
        Start   = 1'b0;
        busy0   = Busy;
        oe0     = AluOE;
        busy_ab = Busy;
        seq     = 16'h0;
        seq[15:12] = AluFuncOp;
        done_at = 99;
        dones   = 0;
        for (int cnt = 1; cnt <= 12; cnt++) begin
            @(posedge Clk); #1;
            if (Done) begin
                dones++;
                if (done_at == 99) done_at = cnt;
            end
            if (cnt < 4 && Busy) seq[15 - 4*cnt -: 4] = AluFuncOp;
            if (glitch && cnt == 1) Start = 1'b1;
            if (glitch && cnt == 2) Start = 1'b0;
            if (abrt && cnt == 2) Abort = 1'b1;
            if (abrt && cnt == 3) begin
                Abort   = 1'b0;
                busy_ab = Busy;
            end
        end
    endtask

    int          d_at;
    int          d_n;
    logic [15:0] sq;
    logic        b0, oe0, bab;

    initial begin
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", {28'd0, Flags}, 32'd0);
        chk("rst_alua", {24'd0, AluA}, 32'd0);
        chk("rst_funcop", {28'd0, AluFuncOp}, 32'd0);
        chk("rst_iflags", {28'd0, AluIFlags}, 32'd0);
        chk("rst_oe", {31'd0, AluOE}, 32'd1);
        @(negedge Clk);
        Reset = 1'b0;

        // ADD with carry ripple through three words
        run_op(2'b00, 32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("add1_busy0", {31'd0, b0}, 32'd1);
        chk("add1_oe0", {31'd0, oe0}, 32'd0);
        chk("add1_done_at", d_at, 32'd4);
        chk("add1_dones", d_n, 32'd1);
        chk("add1_result", Result, 32'h01000000);
        chk("add1_flags", {28'd0, Flags}, 32'h0);
        chk("add1_ops", {16'd0, sq}, 32'h0000);
        chk("add1_idle_busy", {31'd0, Busy}, 32'd0);
        chk("add1_idle_oe", {31'd0, AluOE}, 32'd1);

        // ADD wrap to zero: C=1 Z=1
        run_op(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("add2_result", Result, 32'h00000000);
        chk("add2_flags", {28'd0, Flags}, 32'h3);

        // SUB 5-3 and op code sequence
        run_op(2'b01, 32'h00000005, 32'h00000003, 1'b1, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("sub1_result", Result, 32'h00000002);
        chk("sub1_flags", {28'd0, Flags}, 32'h0);
        chk("sub1_ops", {16'd0, sq}, 32'h1222);
        chk("sub1_done_at", d_at, 32'd4);

        // SUB 0-1: borrow through every word, N=1 C=1
        run_op(2'b01, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("sub2_result", Result, 32'hFFFFFFFF);
        chk("sub2_flags", {28'd0, Flags}, 32'h6);

        // AND to zero: Z=1, carry forced 0
        run_op(2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("and_result", Result, 32'h00000000);
        chk("and_flags", {28'd0, Flags}, 32'h1);
        chk("and_ops", {16'd0, sq}, 32'h3333);

        // ADD with CarryIn into signed overflow: V=1 N=1
        run_op(2'b00, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("addc_result", Result, 32'h80000000);
        chk("addc_flags", {28'd0, Flags}, 32'hC);

        // XOR with Start pulsed during ISSUE
        run_op(2'b11, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1, 1'b1, 1'b0, d_at, d_n, sq, b0, oe0, bab);
        chk("xor_result", Result, 32'h5A5AA5A5);
        chk("xor_flags", {28'd0, Flags}, 32'h0);
        chk("xor_ops", {16'd0, sq}, 32'h6666);
        chk("xor_dones", d_n, 32'd1);
        chk("xor_done_at", d_at, 32'd4);

        // Abort at word 2
        run_op(2'b00, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1, d_at, d_n, sq, b0, oe0, bab);
`ifdef ALU_SEQ_ABORT_EN
        chk("abort_dones", d_n, 32'd0);
        chk("abort_busy", {31'd0, bab}, 32'd0);
        chk("abort_result", Result, 32'h5A5AA5A5);
        chk("abort_flags", {28'd0, Flags}, 32'h0);
`else
        chk("abort_dones", d_n, 32'd1);
        chk("abort_busy", {31'd0, bab}, 32'd1);
        chk("abort_result", Result, 32'h33333333);
        chk("abort_done_at", d_at, 32'd4);
`endif

        // Reset asserted mid-ISSUE clears outputs without a clock edge
        @(negedge Clk);
        OpSel = 2'b00; OpA = 32'h12345678; OpB = 32'h11111111; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("mid_busy_pre", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("mid_busy", {31'd0, Busy}, 32'd0);
        chk("mid_done", {31'd0, Done}, 32'd0);
        chk("mid_result", Result, 32'd0);
        chk("mid_flags", {28'd0, Flags}, 32'd0);
        chk("mid_oe", {31'd0, AluOE}, 32'd1);
        chk("mid_funcop", {28'd0, AluFuncOp}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        chk("mid_no_done", {31'd0, Done}, 32'd0);
        chk("mid_result_hold", Result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
